// File: rtl/nuc_pattern_scanner.sv
// nuc_pattern_scanner: streams nucleotides from address 0 and counts windows matching a pattern
// within a mismatch tolerance, reporting the first matching window's start address.
module nuc_pattern_scanner #(
    parameter int NUC_DEPTH = 65536,
    parameter int PAT_LEN = 4,
    localparam int AW = $clog2(NUC_DEPTH),
    localparam int MW = $clog2(PAT_LEN + 1)
) (
    input  logic                 clock,
    input  logic                 reset_L,
    input  logic                 start,
    input  logic [2*PAT_LEN-1:0] pattern,
    input  logic [MW-1:0]        max_mismatch,
    input  logic [AW:0]          length,
    output logic                 nuc_re,
    output logic [AW-1:0]        nuc_addr,
    input  logic [1:0]           nuc_data,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [AW:0]          match_count,
    output logic [AW-1:0]        first_match_addr
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(NUC_DEPTH);
    localparam logic [MW-1:0] FULL = MW'(PAT_LEN);
    state_t state, state_n;
    logic [2*PAT_LEN-1:0] window, pat_q, win_n;
    logic [MW-1:0] fill, fill_n, mm_q, diff;
    logic [AW:0] len_q, len_c;
    logic [AW-1:0] addr;
    logic accept, last, hit;
    assign len_c = length > DEPTH_L ? DEPTH_L : length;
    assign accept = start && state != SCAN;
    assign last = {1'b0, addr} == len_q - 1'b1;
    // newest nucleotide enters at the LSBs so the oldest sits where the pattern's first one does
    assign win_n = (window << 2) | (2*PAT_LEN)'(nuc_data);
    assign fill_n = fill == FULL ? FULL : fill + 1'b1;
    assign hit = fill_n == FULL && diff <= mm_q;
    assign busy = state == SCAN;
    assign done = state == DONE;
    assign nuc_re = busy;
    assign nuc_addr = busy ? addr : '0;
    always_comb begin
        diff = '0;
        for (int i = 0; i < PAT_LEN; i++)
            diff = diff + MW'(win_n[2*i +: 2] != pat_q[2*i +: 2]);
    end
    always_comb begin
        state_n = state;
        if (accept)
            state_n = len_c == '0 ? DONE : SCAN;
        else if (state == SCAN && last)
            state_n = DONE;
    end
    always_ff @(posedge clock or negedge reset_L)
        if (!reset_L) begin
            state <= IDLE;
            window <= '0;
            fill <= '0;
            addr <= '0;
            pat_q <= '0;
            mm_q <= '0;
            len_q <= '0;
            match_count <= '0;
            found <= 1'b0;
            first_match_addr <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                window <= '0;
                fill <= '0;
                addr <= '0;
                pat_q <= pattern;
                mm_q <= max_mismatch;
                len_q <= len_c;
                match_count <= '0;
                found <= 1'b0;
                first_match_addr <= '0;
            end else if (state == SCAN) begin
                window <= win_n;
                fill <= fill_n;
                addr <= addr + 1'b1;
                if (hit) begin
                    match_count <= match_count + 1'b1;
                    if (!found) begin
                        found <= 1'b1;
                        first_match_addr <= addr - AW'(PAT_LEN - 1);
                    end
                end
            end
        end
endmodule

// File: doc/nuc_pattern_scanner.md
# nuc_pattern_scanner

Streaming nucleotide pattern matcher that sits between the nucleotide memory (2-bit words, asynchronous read) and the result/display logic. On `start` it reads a programmable number of nucleotides from address 0 upward and slides a PAT_LEN-nucleotide window across them. It counts every window that matches the pattern within a programmable mismatch tolerance, overlapping windows included, and reports the address of the first match. It generalises the fixed-size pattern memory path to any pattern length, any memory depth and approximate matching.

## Interface
Parameters:
- `NUC_DEPTH`, 65536, number of nucleotide words addressable; AW = $clog2(NUC_DEPTH)
- `PAT_LEN`, 4, pattern length in nucleotides (≥1); MW = $clog2(PAT_LEN+1)

Ports:
- `clock`  in  1  single clock; all state on rising edge
- `reset_L`  in  1  asynchronous, active-low reset
- `start`  in  1  begin scan; honoured only in IDLE or DONE
- `pattern`  in  2*PAT_LEN  pattern; first nucleotide in MSBs; sampled on accepted start
- `max_mismatch`  in  MW  allowed mismatching positions per window; sampled on accepted start
- `length`  in  AW+1  nucleotides to scan; sampled on accepted start, clamped to NUC_DEPTH
- `nuc_re`  out  1  memory read enable
- `nuc_addr`  out  AW  memory address
- `nuc_data`  in  2  memory read data, valid in the same cycle as `nuc_addr`
- `busy`  out  1  high in SCAN
- `done`  out  1  high in DONE
- `found`  out  1  at least one match in last scan
- `match_count`  out  AW+1  matches in last scan
- `first_match_addr`  out  AW  start address of first matching window; 0 if none

## Operation
- Encoding: A=00, C=01, G=10, T=11.
- FSM states: IDLE, SCAN, DONE.
  - IDLE/DONE + start → clear window, fill count, `match_count`, `found`, `first_match_addr`; addr←0; latch inputs; go to SCAN, or straight to DONE if clamped length = 0.
  - SCAN: each cycle drive `nuc_re`=1, `nuc_addr`=addr; on the edge, shift `nuc_data` into window LSBs (oldest falls out of MSBs), fill count saturates at PAT_LEN, addr++. When addr reaches length−1 on this edge, go to DONE.
  - DONE: results held stable until the next accepted start; `start` otherwise ignored.
- Match evaluation happens on the same edge as the shift, using the next window value. A window counts only once fill count (including the new nucleotide) = PAT_LEN. Match iff number of differing 2-bit positions ≤ latched `max_mismatch`.
- On a match: `match_count`++. If `found` was 0, then `first_match_addr` ← addr − (PAT_LEN−1) and `found` ← 1.
- Overlapping matches are all counted. length < PAT_LEN gives zero matches but still scans length cycles.
- `max_mismatch` ≥ PAT_LEN: every full window matches.
- `start` during SCAN is ignored. Input changes after start have no effect.
- `nuc_re`=0 and `nuc_addr`=0 outside SCAN.

## Timing
- Reset (`reset_L` low, any time, asynchronous): state IDLE; all outputs 0; window, fill count and addr cleared. Reset mid-scan aborts with no residual state.
- Start accepted at edge t, length L ≥ 1:
  - SCAN occupies cycles t+1 … t+L.
  - `nuc_addr` = i during cycle t+1+i.
  - `busy` high exactly L cycles.
  - `done` high from cycle t+L+1.
- L = 0: `done` high from cycle t+1; `busy` never asserted.
- Results are final when `done` rises.
- Restart from DONE: `done` drops and results clear in the cycle after the accepting edge.
- Throughput: one nucleotide per clock, no stalls.

## Test plan
- Memory ACGTACGT, pattern 8'b00_01_10_11 (ACGT), max_mismatch 0, length 8 → `busy` for 8 cycles, `done` at cycle 9, match_count 2, found 1, first_match_addr 0.
- Memory AAAAAA, pattern AAAA, max_mismatch 0, length 6 → match_count 3 (overlaps), first_match_addr 0.
- Memory ACGAACGT, pattern ACGT, length 8: max_mismatch 1 → count 2, first 0; max_mismatch 0 → count 1, first 4.
- length 3 with PAT_LEN 4 → count 0, found 0, `done` at cycle 4. length 0 → `done` at cycle 1, `nuc_re` never high.
- Pulse start with different length and pattern during SCAN → ignored; results match the original scan.
- Assert `reset_L` low mid-scan → all outputs 0 immediately. Restart the scan → results identical to the first test.
